// File: rtl/split_adder_resolver.sv
// Multi-cycle wide adder using segmented addition with carry re-injection.
// Operands are cut into SS-bit segments that are added in parallel; each
// segment's carry is fed into the segment above on the next cycle until no
// carries remain. With wrap=1 the top carry goes back into bit 0, so the
// result is an end-around-carry (mod 2^IO-1) sum. All-ones is a legal
// wrap result (negative zero).
//
// Needs at least two segments (IO > SS).
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | ready for operands; round 1 is computed on the accept edge
//   RES   | carries still pending; one re-injection round per cycle
//   DONE  | result valid, held until out_ready
module split_adder_resolver #(
  parameter  int IO      = 1024,
  parameter  int SS      = 32,
  localparam int N_PARTS = (IO + SS - 1) / SS,
  localparam int RND_W   = $clog2(N_PARTS + 2)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IO-1:0]    a,
  input  logic [IO-1:0]    b,
  input  logic             cin,
  input  logic             wrap,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IO-1:0]    sum,
  output logic             cout,
  output logic [RND_W-1:0] rounds
);

  localparam int LO     = (N_PARTS - 1) * SS;
  localparam int LAST_W = IO - LO;

  typedef enum logic [1:0] {IDLE, RES, DONE} state_t;

  state_t             state_q, state_d;
  logic [IO-1:0]      sum_q;
  logic [N_PARTS-1:0] carry_q;
  logic               wrap_q;
  logic               cout_q;
  logic [RND_W-1:0]   rounds_q;

  logic [IO-1:0]      op_x, op_y, s_nxt;
  logic [N_PARTS-1:0] k_vec, c_nxt;
  logic               wrap_eff;
  logic               accept;
  logic               pending;

  assign accept = (state_q == IDLE) && in_valid;

  // Operand select: fresh operands with cin in IDLE, otherwise the
  // registered partial sum plus carries shifted up one segment.
  always_comb begin
    op_x     = sum_q;
    op_y     = '0;
    k_vec    = {carry_q[N_PARTS-2:0], wrap_q & carry_q[N_PARTS-1]};
    wrap_eff = wrap_q;
    if (state_q == IDLE) begin
      op_x     = a;
      op_y     = b;
      k_vec    = {{(N_PARTS-1){1'b0}}, cin};
      wrap_eff = wrap;
    end
  end

  // Full-width segments, each with its own carry out.
  for (genvar g = 0; g < N_PARTS - 1; g++) begin : g_seg
    logic [SS:0] t;
    assign t = {1'b0, op_x[g*SS +: SS]} + {1'b0, op_y[g*SS +: SS]}
             + {{SS{1'b0}}, k_vec[g]};
    assign s_nxt[g*SS +: SS] = t[SS-1:0];
    assign c_nxt[g]          = t[SS];
  end

  // Last segment may be narrower; its carry is the carry out of bit IO-1.
  logic [LAST_W:0] t_last;
  assign t_last = {1'b0, op_x[IO-1:LO]} + {1'b0, op_y[IO-1:LO]}
                + {{LAST_W{1'b0}}, k_vec[N_PARTS-1]};
  assign s_nxt[IO-1:LO]      = t_last[LAST_W-1:0];
  assign c_nxt[N_PARTS-1]    = t_last[LAST_W];

  // Another round is needed if any carry would be injected next cycle.
  assign pending = (|c_nxt[N_PARTS-2:0]) | (wrap_eff & c_nxt[N_PARTS-1]);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = pending ? RES : DONE;
      end
      RES: begin
        if (!pending) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: round 1 on acceptance, one re-injection round per RES cycle.
  // Without wrap the top carry only feeds the sticky cout.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q    <= '0;
      carry_q  <= '0;
      wrap_q   <= 1'b0;
      cout_q   <= 1'b0;
      rounds_q <= '0;
    end else if (accept) begin
      sum_q    <= s_nxt;
      carry_q  <= c_nxt;
      wrap_q   <= wrap;
      cout_q   <= ~wrap & c_nxt[N_PARTS-1];
      rounds_q <= RND_W'(1);
    end else if (state_q == RES) begin
      sum_q    <= s_nxt;
      carry_q  <= c_nxt;
      cout_q   <= cout_q | (~wrap_q & c_nxt[N_PARTS-1]);
      rounds_q <= rounds_q + RND_W'(1);
    end
  end

  assign sum    = sum_q;
  assign cout   = cout_q;
  assign rounds = rounds_q;

endmodule

// File: tb/tb_split_adder_resolver.sv
// Bench for split_adder_resolver: directed cases on a 16/4 instance, then
// randomized operands on 16/4, 20/8 and 1024/32 instances checked against
// a plain-arithmetic model of a+b+cin (optionally folded mod 2^IO-1).
module tb_split_adder_resolver;

  localparam int CW = 1025;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  // Single comparison point for the whole bench.
  task automatic chk_val(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] want);
    n_chk++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h (low 128 bits)", tag, got[127:0], want[127:0]);
    end
  endtask

  // ---------------- directed instance (IO=16, SS=4) ----------------
  logic        d_rst;
  logic        d_in_valid, d_in_ready;
  logic [15:0] d_a, d_b, d_sum;
  logic        d_cin, d_wrap, d_out_valid, d_out_ready, d_cout;
  logic [2:0]  d_rounds;
  logic        rst;

  split_adder_resolver #(.IO(16), .SS(4)) u_dir (
    .clk(clk), .rst(d_rst), .in_valid(d_in_valid), .in_ready(d_in_ready),
    .a(d_a), .b(d_b), .cin(d_cin), .wrap(d_wrap),
    .out_valid(d_out_valid), .out_ready(d_out_ready),
    .sum(d_sum), .cout(d_cout), .rounds(d_rounds)
  );

  // Present one operand pair, let it be accepted, scramble the inputs and
  // count negedges until out_valid (1 = valid right after the accept edge).
  task automatic d_run(input logic [15:0] ta, input logic [15:0] tb_v,
                       input logic tc, input logic tw, output int lat);
    d_a = ta; d_b = tb_v; d_cin = tc; d_wrap = tw; d_in_valid = 1'b1;
    @(negedge clk);
    d_in_valid = 1'b0; d_wrap = ~tw; d_a = 16'h5a5a; d_b = 16'ha5a5; d_cin = ~tc;
    lat = 1;
    while (!d_out_valid && lat < 12) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic d_release();
    d_out_ready = 1'b1;
    @(negedge clk);
    d_out_ready = 1'b0;
    chk_val("rel_out_valid", CW'(d_out_valid), CW'(0));
    chk_val("rel_in_ready", CW'(d_in_ready), CW'(1));
  endtask

  // ---------------- random instances ----------------
  for (genvar gi = 0; gi < 3; gi++) begin : g_rnd
    localparam int GIO  = (gi == 0) ? 16 : (gi == 1) ? 20 : 1024;
    localparam int GSS  = (gi == 0) ? 4  : (gi == 1) ? 8  : 32;
    localparam int GN   = (GIO + GSS - 1) / GSS;
    localparam int GRW  = $clog2(GN + 2);
    localparam int NOPS = (GIO > 64) ? 1500 : 3000;

    logic           r_in_valid, r_in_ready, r_cin, r_wrap;
    logic           r_out_valid, r_out_ready, r_cout;
    logic [GIO-1:0] r_a, r_b, r_sum;
    logic [GRW-1:0] r_rounds;
    logic           done_f = 1'b0;

    split_adder_resolver #(.IO(GIO), .SS(GSS)) u_dut (
      .clk(clk), .rst(rst), .in_valid(r_in_valid), .in_ready(r_in_ready),
      .a(r_a), .b(r_b), .cin(r_cin), .wrap(r_wrap),
      .out_valid(r_out_valid), .out_ready(r_out_ready),
      .sum(r_sum), .cout(r_cout), .rounds(r_rounds)
    );

    function automatic logic [GIO-1:0] rnd_w();
      logic [GIO-1:0] r;
      r = '0;
      for (int i = 0; i < (GIO + 31) / 32; i++) r = (r << 32) | GIO'($urandom);
      return r;
    endfunction

    initial begin : rnd_proc
      logic [GIO-1:0] ra, rb, es;
      logic [GIO:0]   t;
      logic           rc, rw, ec, hs;
      int             cnt, bound;
      r_in_valid = 1'b0; r_out_ready = 1'b0; r_a = '0; r_b = '0;
      r_cin = 1'b0; r_wrap = 1'b0;
      repeat (5) @(negedge clk);
      chk_val("rnd_rst_ready", CW'(r_in_ready), CW'(1));
      chk_val("rnd_rst_rounds", CW'(r_rounds), CW'(0));
      for (int op = 0; op < NOPS; op++) begin
        ra = rnd_w();
        case ($urandom_range(0, 3))
          0: rb = rnd_w();
          1: rb = ~ra;
          2: begin ra = '1; rb = GIO'($urandom_range(0, 3)); end
          default: rb = rnd_w() & ~ra;
        endcase
        rc = 1'($urandom_range(0, 1));
        rw = 1'($urandom_range(0, 1));
        // Reference: integer sum, folded back into IO bits when wrapping.
        t = {1'b0, ra} + {1'b0, rb} + (GIO+1)'(rc);
        if (rw) begin
          while (t[GIO]) t = {1'b0, t[GIO-1:0]} + (GIO+1)'(1);
          ec = 1'b0;
        end else begin
          ec = t[GIO];
        end
        es = t[GIO-1:0];
        bound = rw ? GN + 1 : GN;

        chk_val("rnd_acc_ready", CW'(r_in_ready), CW'(1));
        r_a = ra; r_b = rb; r_cin = rc; r_wrap = rw; r_in_valid = 1'b1;
        @(negedge clk);
        cnt = 1;
        while (!r_out_valid && cnt < GN + 4) begin
          r_in_valid = 1'($urandom_range(0, 1));
          r_a = rnd_w(); r_b = rnd_w(); r_wrap = ~rw; r_cin = ~rc;
          @(negedge clk);
          cnt++;
        end
        r_in_valid = 1'b0; r_wrap = ~rw;
        chk_val("rnd_out_valid", CW'(r_out_valid), CW'(1));
        chk_val("rnd_rounds_hi", CW'(int'(r_rounds) <= bound), CW'(1));
        chk_val("rnd_rounds_lo", CW'(r_rounds != '0), CW'(1));
        hs = 1'b0;
        while (!hs) begin
          chk_val("rnd_sum", CW'(r_sum), CW'(es));
          chk_val("rnd_cout", CW'(r_cout), CW'(ec));
          chk_val("rnd_busy_ready", CW'(r_in_ready), CW'(0));
          r_out_ready = ($urandom_range(0, 2) != 0);
          hs = r_out_ready;
          @(negedge clk);
        end
        r_out_ready = 1'b0;
        chk_val("rnd_hs_valid", CW'(r_out_valid), CW'(0));
      end
      done_f = 1'b1;
    end
  end

  // ---------------- directed sequence and summary ----------------
  initial begin
    int lat, w;
    rst = 1'b1; d_rst = 1'b1;
    d_in_valid = 1'b0; d_out_ready = 1'b0; d_a = '0; d_b = '0; d_cin = 1'b0; d_wrap = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0; d_rst = 1'b0;

    chk_val("rst_in_ready", CW'(d_in_ready), CW'(1));
    chk_val("rst_out_valid", CW'(d_out_valid), CW'(0));
    chk_val("rst_sum", CW'(d_sum), CW'(0));
    chk_val("rst_cout", CW'(d_cout), CW'(0));
    chk_val("rst_rounds", CW'(d_rounds), CW'(0));

    // 3 + 4, no carries
    d_run(16'h0003, 16'h0004, 1'b0, 1'b0, lat);
    chk_val("c1_sum", CW'(d_sum), CW'(16'h0007));
    chk_val("c1_cout", CW'(d_cout), CW'(0));
    chk_val("c1_rounds", CW'(d_rounds), CW'(1));
    chk_val("c1_lat", CW'(lat), CW'(1));
    d_release();

    // FFFF + 1 ripples through all four segments
    d_run(16'hffff, 16'h0001, 1'b0, 1'b0, lat);
    chk_val("c2_sum", CW'(d_sum), CW'(16'h0000));
    chk_val("c2_cout", CW'(d_cout), CW'(1));
    chk_val("c2_rounds", CW'(d_rounds), CW'(4));
    chk_val("c2_lat", CW'(lat), CW'(4));
    d_release();

    // same with end-around carry; wrap is flipped after accept
    d_run(16'hffff, 16'h0001, 1'b0, 1'b1, lat);
    chk_val("c3_sum", CW'(d_sum), CW'(16'h0001));
    chk_val("c3_cout", CW'(d_cout), CW'(0));
    chk_val("c3_rounds", CW'(d_rounds), CW'(5));
    chk_val("c3_lat", CW'(lat), CW'(5));
    d_release();

    // negative zero stays all-ones
    d_run(16'hffff, 16'h0000, 1'b0, 1'b1, lat);
    chk_val("c3b_sum", CW'(d_sum), CW'(16'hffff));
    chk_val("c3b_rounds", CW'(d_rounds), CW'(1));
    d_release();

    // backpressure with a second operand waiting
    d_run(16'hffff, 16'h0001, 1'b0, 1'b0, lat);
    d_a = 16'h1234; d_b = 16'h1111; d_cin = 1'b1; d_wrap = 1'b0; d_in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_val("c4_hold_sum", CW'(d_sum), CW'(16'h0000));
      chk_val("c4_hold_cout", CW'(d_cout), CW'(1));
      chk_val("c4_hold_rounds", CW'(d_rounds), CW'(4));
      chk_val("c4_hold_valid", CW'(d_out_valid), CW'(1));
      chk_val("c4_hold_ready", CW'(d_in_ready), CW'(0));
    end
    d_out_ready = 1'b1;
    @(negedge clk);
    d_out_ready = 1'b0;
    chk_val("c4_hs_valid", CW'(d_out_valid), CW'(0));
    chk_val("c4_hs_ready", CW'(d_in_ready), CW'(1));
    @(negedge clk);
    d_in_valid = 1'b0;
    lat = 1;
    while (!d_out_valid && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    chk_val("c4_sum", CW'(d_sum), CW'(16'h2346));
    chk_val("c4_cout", CW'(d_cout), CW'(0));
    chk_val("c4_rounds", CW'(d_rounds), CW'(1));
    chk_val("c4_lat", CW'(lat), CW'(1));
    d_release();

    // reset in the middle of the ripple
    d_a = 16'hffff; d_b = 16'h0001; d_cin = 1'b0; d_wrap = 1'b0; d_in_valid = 1'b1;
    @(negedge clk);
    d_in_valid = 1'b0; d_rst = 1'b1;
    @(negedge clk);
    d_rst = 1'b0;
    chk_val("c5_out_valid", CW'(d_out_valid), CW'(0));
    chk_val("c5_in_ready", CW'(d_in_ready), CW'(1));
    chk_val("c5_rounds", CW'(d_rounds), CW'(0));
    chk_val("c5_sum", CW'(d_sum), CW'(0));
    chk_val("c5_cout", CW'(d_cout), CW'(0));
    d_run(16'h00ff, 16'h0001, 1'b0, 1'b0, lat);
    chk_val("c5b_sum", CW'(d_sum), CW'(16'h0100));
    chk_val("c5b_rounds", CW'(d_rounds), CW'(3));
    chk_val("c5b_lat", CW'(lat), CW'(3));
    d_release();

    w = 0;
    while (!(g_rnd[0].done_f && g_rnd[1].done_f && g_rnd[2].done_f) && w < 90000) begin
      @(negedge clk);
      w++;
    end
    chk_val("rnd_all_done",
            CW'(g_rnd[0].done_f && g_rnd[1].done_f && g_rnd[2].done_f), CW'(1));

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
